cdr_loop_filter: RTL and testbench
==================================

// Module: cdr_loop_filter
// PURPOSE
//  Digital loop filter directly downstream of the Alexander phase detector in the CDR.
//  - Consumes the per-bit transition (T) and early (E) decisions.
//  - Integrates early/late votes in a signed accumulator.
//  - When a threshold is crossed, emits one-cycle up/down correction pulses and steps a
//    modulo-N sampling-phase index.
//  - Flags lock after a run of correction-free decisions.
// PARAMETERS
//  THRESH    8   vote magnitude that triggers a correction (1..2^(ACC_W-1)-1)
//  ACC_W     5   signed accumulator width in bits
//  HOLDOFF   4   valid strobes ignored after each correction (loop settle); 0 = none
//  LOCK_CNT  32  consecutive correction-free valid strobes needed to assert o_lock
//  N_PHASES  16  number of selectable sampling phases
//  PH_W      4   width of o_phase_sel, >= clog2(N_PHASES)
// PORTS
//  i_clk        in   1     system clock, 50 MHz, rising edge
//  i_rst        in   1     asynchronous active-low reset
//  i_enable     in   1     1 = loop closed; 0 = freeze phase, clear votes
//  i_pd_valid   in   1     one-cycle strobe: i_T/i_E hold a fresh decision
//  i_T          in   1     transition detected on this bit
//  i_E          in   1     with i_T=1: 1 = sampling early, 0 = sampling late
//  o_up         out  1     one-cycle pulse: phase index incremented (sample later)
//  o_dn         out  1     one-cycle pulse: phase index decremented (sample earlier)
//  o_phase_sel  out  PH_W  current sampling-phase index, 0..N_PHASES-1
//  o_lock       out  1     loop locked
// BEHAVIOUR
//  Reset (i_rst=0, async): state=IDLE, acc=0, hold_cnt=0, lock_cnt=0.
//   Outputs: o_up=0, o_dn=0, o_phase_sel=0, o_lock=0. Reset mid-operation aborts
//   everything immediately.
//  All outputs are registered. Inputs are sampled on the rising i_clk edge.
//  Vote on an i_pd_valid cycle:
//   - i_T=1, i_E=1: +1
//   - i_T=1, i_E=0: -1
//   - i_T=0: 0 (no transition; acc unchanged, but counts toward lock)
//  State machine:
//   IDLE:  o_up/o_dn=0, acc=0, o_phase_sel held. Goes to TRACK on the edge that
//          samples i_enable=1.
//   TRACK: on valid, acc_next = acc + vote.
//          - acc_next >= +THRESH: o_up=1 next cycle, phase+1, acc=0.
//          - acc_next <= -THRESH: o_dn=1 next cycle, phase-1, acc=0.
//          - After a correction: hold_cnt=HOLDOFF, go to HOLD if HOLDOFF>0.
//          - Otherwise acc=acc_next. Accumulation cannot overflow given the THRESH bound.
//   HOLD:  valid strobes only decrement hold_cnt; votes are discarded. Return to TRACK
//          on the strobe that brings hold_cnt to 0. Non-valid cycles do nothing.
//   i_enable=0 in any state: go to IDLE next edge, acc=0, hold_cnt=0, lock_cnt=0,
//   o_lock=0. A correction pending in that same cycle is dropped.
//  Latency: valid at edge k -> o_up/o_dn high for exactly the cycle after edge k.
//   o_phase_sel updates on the same edge. Never both pulses high together.
//  Phase wrap:
//   - up at N_PHASES-1 -> 0.
//   - dn at 0 -> N_PHASES-1.
//  Lock:
//   - lock_cnt counts valid strobes in TRACK/HOLD and saturates at LOCK_CNT.
//   - Cleared to 0 on every correction.
//   - o_lock = (lock_cnt == LOCK_CNT), registered.
//   - A correction drops o_lock on the same edge the pulse rises.
//  i_pd_valid while i_enable=0 is ignored. i_T/i_E are don't-care when
//  i_pd_valid=0.
// TESTING
//  Reset check: assert i_rst=0 mid-run -> all outputs 0 asynchronously; after release
//   state is IDLE, o_phase_sel=0.
//  Advance: enable, 8 valid strobes T=1,E=1 -> single o_up pulse one cycle after the
//   8th strobe, o_phase_sel=1, acc=0. Then 4 strobes ignored (HOLD). The 5th strobe
//   counts again.
//  Wrap-around, retard side: from phase 0, 8 strobes T=1,E=0 -> o_dn pulse,
//   o_phase_sel=15.
//  Wrap-around, advance side: from phase 15, 8 early strobes -> o_phase_sel=0.
//  Mixed votes: alternating early/late x40 -> no pulse; acc stays within +/-1.
//   o_lock rises after the 32nd strobe.
//  Lock loss and disable: locked, then 8 early strobes -> o_up and o_lock fall on the
//   same edge. Drop i_enable with acc=7 -> next early strobe gives no pulse, acc=0.

Source files
------------

// File: rtl/cdr_loop_filter.sv
// Digital loop filter for the CDR. It integrates Alexander phase-detector votes
// and steps a modulo-N sampling-phase index when a vote threshold is crossed.
module cdr_loop_filter #(
    parameter int unsigned THRESH   = 8,
    parameter int unsigned ACC_W    = 5,
    parameter int unsigned HOLDOFF  = 4,
    parameter int unsigned LOCK_CNT = 32,
    parameter int unsigned N_PHASES = 16,
    parameter int unsigned PH_W     = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_enable,
    input  logic            i_pd_valid,
    input  logic            i_T,
    input  logic            i_E,
    output logic            o_up,
    output logic            o_dn,
    output logic [PH_W-1:0] o_phase_sel,
    output logic            o_lock
);

    localparam int unsigned HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int unsigned LOCK_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned SUM_W  = ACC_W + 1;

    localparam logic signed [SUM_W-1:0]  THR_P    = SUM_W'(THRESH);
    localparam logic signed [SUM_W-1:0]  THR_N    = -THR_P;
    localparam logic        [HOLD_W-1:0] HOLD_INI = HOLD_W'(HOLDOFF);
    localparam logic        [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);
    localparam logic        [PH_W-1:0]   PH_MAX   = PH_W'(N_PHASES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [SUM_W-1:0]   acc_ext;
    logic signed [SUM_W-1:0]   vote;
    logic signed [SUM_W-1:0]   acc_sum;
    logic        [HOLD_W-1:0]  hold_cnt;
    logic        [HOLD_W-1:0]  hold_next;
    logic        [LOCK_W-1:0]  lock_cnt;
    logic        [LOCK_W-1:0]  lock_next;
    logic        [LOCK_W-1:0]  lock_sat;
    logic        [PH_W-1:0]    phase_next;
    logic        [PH_W-1:0]    phase_inc;
    logic        [PH_W-1:0]    phase_dec;
    logic                      up_next;
    logic                      dn_next;
    logic                      lock_out_next;

    // State and all registered outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= IDLE;
            acc         <= '0;
            hold_cnt    <= '0;
            lock_cnt    <= '0;
            o_up        <= 1'b0;
            o_dn        <= 1'b0;
            o_phase_sel <= '0;
            o_lock      <= 1'b0;
        end else begin
            state       <= state_next;
            acc         <= acc_next;
            hold_cnt    <= hold_next;
            lock_cnt    <= lock_next;
            o_up        <= up_next;
            o_dn        <= dn_next;
            o_phase_sel <= phase_next;
            o_lock      <= lock_out_next;
        end
    end

    // Next-state, vote integration, phase stepping and lock tracking
    always_comb begin
        state_next = state;
        acc_next   = acc;
        hold_next  = hold_cnt;
        lock_next  = lock_cnt;
        phase_next = o_phase_sel;
        up_next    = 1'b0;
        dn_next    = 1'b0;

        // Early = +1, late = -1, no transition = 0
        vote     = i_T ? (i_E ? SUM_W'(1) : -SUM_W'(1)) : '0;
        acc_ext  = {acc[ACC_W-1], acc};
        acc_sum  = acc_ext + vote;
        lock_sat = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LOCK_W'(1);

        phase_inc = (o_phase_sel == PH_MAX) ? '0 : o_phase_sel + PH_W'(1);
        phase_dec = (o_phase_sel == '0) ? PH_MAX : o_phase_sel - PH_W'(1);

        if (!i_enable) begin
            // Opening the loop drops any pending correction and all history
            state_next = IDLE;
            acc_next   = '0;
            hold_next  = '0;
            lock_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    acc_next   = '0;
                    state_next = TRACK;
                end
                TRACK: begin
                    if (i_pd_valid) begin
                        lock_next = lock_sat;
                        if (acc_sum >= THR_P) begin
                            up_next    = 1'b1;
                            phase_next = phase_inc;
                            acc_next   = '0;
                            lock_next  = '0;
                            hold_next  = HOLD_INI;
                            if (HOLDOFF > 0) state_next = HOLD;
                        end else if (acc_sum <= THR_N) begin
                            dn_next    = 1'b1;
                            phase_next = phase_dec;
                            acc_next   = '0;
                            lock_next  = '0;
                            hold_next  = HOLD_INI;
                            if (HOLDOFF > 0) state_next = HOLD;
                        end else begin
                            acc_next = acc_sum[ACC_W-1:0];
                        end
                    end
                end
                HOLD: begin
                    // Votes are discarded while the loop settles
                    if (i_pd_valid) begin
                        lock_next = lock_sat;
                        if (hold_cnt <= HOLD_W'(1)) begin
                            hold_next  = '0;
                            state_next = TRACK;
                        end else begin
                            hold_next = hold_cnt - HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    acc_next   = '0;
                    hold_next  = '0;
                    lock_next  = '0;
                end
            endcase
        end

        lock_out_next = (lock_next == LOCK_MAX);
    end

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Self-checking bench for cdr_loop_filter: directed scenarios plus random
// stimulus, compared cycle by cycle against an arithmetic reference model.
module tb_cdr_loop_filter;

    localparam int THRESH   = 8;
    localparam int ACC_W    = 5;
    localparam int HOLDOFF  = 4;
    localparam int LOCK_CNT = 32;
    localparam int N_PHASES = 16;
    localparam int PH_W     = 4;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic            pd_valid;
    logic            t_in;
    logic            e_in;
    logic            up;
    logic            dn;
    logic [PH_W-1:0] phase_sel;
    logic            lock;

    int n_cmp;
    int n_bad;

    // Reference model state
    bit m_closed;
    int m_acc;
    int m_hold;
    int m_run;
    int m_phase;
    bit m_up;
    bit m_dn;
    bit m_lock;

    cdr_loop_filter #(
        .THRESH  (THRESH),
        .ACC_W   (ACC_W),
        .HOLDOFF (HOLDOFF),
        .LOCK_CNT(LOCK_CNT),
        .N_PHASES(N_PHASES),
        .PH_W    (PH_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_enable   (enable),
        .i_pd_valid (pd_valid),
        .i_T        (t_in),
        .i_E        (e_in),
        .o_up       (up),
        .o_dn       (dn),
        .o_phase_sel(phase_sel),
        .o_lock     (lock)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_closed = 0;
        m_acc    = 0;
        m_hold   = 0;
        m_run    = 0;
        m_phase  = 0;
        m_up     = 0;
        m_dn     = 0;
        m_lock   = 0;
    endfunction

    // One clock edge of the loop filter, described in terms of votes and runs
    function automatic void model_step(bit en, bit v, bit t, bit e);
        m_up = 0;
        m_dn = 0;
        if (!en) begin
            m_closed = 0;
            m_acc    = 0;
            m_hold   = 0;
            m_run    = 0;
        end else if (!m_closed) begin
            m_closed = 1;
            m_acc    = 0;
        end else if (v) begin
            if (m_run < LOCK_CNT) m_run++;
            if (m_hold > 0) begin
                m_hold--;
            end else begin
                m_acc += t ? (e ? 1 : -1) : 0;
                if (m_acc >= THRESH) begin
                    m_up    = 1;
                    m_phase = (m_phase + 1) % N_PHASES;
                end else if (m_acc <= -THRESH) begin
                    m_dn    = 1;
                    m_phase = (m_phase + N_PHASES - 1) % N_PHASES;
                end
                if (m_up || m_dn) begin
                    m_acc  = 0;
                    m_run  = 0;
                    m_hold = HOLDOFF;
                end
            end
        end
        m_lock = (m_run == LOCK_CNT);
    endfunction

    task automatic compare_all();
        check("up", int'(up), int'(m_up));
        check("dn", int'(dn), int'(m_dn));
        check("phase", int'(phase_sel), m_phase);
        check("lock", int'(lock), int'(m_lock));
        check("excl", int'(up & dn), 0);
    endtask

    task automatic cycle(input bit en, input bit v, input bit t, input bit e);
        enable   = en;
        pd_valid = v;
        t_in     = t;
        e_in     = e;
        @(posedge clk);
        model_step(en, v, t, e);
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #4;
        rst_n = 1'b0;
        #1;
        check("rst_up", int'(up), 0);
        check("rst_dn", int'(dn), 0);
        check("rst_phase", int'(phase_sel), 0);
        check("rst_lock", int'(lock), 0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int p_early;
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        pd_valid = 1'b0;
        t_in     = 1'b0;
        e_in     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Close the loop, then advance by one phase
        cycle(1, 0, 0, 0);
        repeat (7) cycle(1, 1, 1, 1);
        cycle(1, 1, 1, 1);
        check("adv_up", int'(up), 1);
        check("adv_phase", int'(phase_sel), 1);
        repeat (HOLDOFF) cycle(1, 1, 1, 1);
        cycle(1, 0, 1, 1);
        check("hold_no_pulse", int'(up), 0);

        // Retard back to 0, then wrap below 0
        repeat (8) cycle(1, 1, 1, 0);
        check("ret_phase0", int'(phase_sel), 0);
        repeat (HOLDOFF) cycle(1, 1, 1, 0);
        repeat (8) cycle(1, 1, 1, 0);
        check("wrap_dn_pulse", int'(dn), 1);
        check("wrap_dn_phase", int'(phase_sel), 15);
        repeat (HOLDOFF) cycle(1, 1, 1, 1);

        // Wrap above N_PHASES-1
        repeat (8) cycle(1, 1, 1, 1);
        check("wrap_up_phase", int'(phase_sel), 0);
        repeat (HOLDOFF) cycle(1, 1, 0, 0);

        // Fresh lock run with alternating votes
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            cycle(1, 1, 1, (i % 2) == 0);
            if (i == 30) check("lock_early", int'(lock), 0);
            if (i == 31) check("lock_rise", int'(lock), 1);
        end

        // Lock lost on the correction edge
        repeat (7) cycle(1, 1, 1, 1);
        check("still_locked", int'(lock), 1);
        cycle(1, 1, 1, 1);
        check("loss_up", int'(up), 1);
        check("loss_lock", int'(lock), 0);
        repeat (HOLDOFF) cycle(1, 1, 0, 0);

        // Disable with acc=7 clears the votes
        repeat (7) cycle(1, 1, 1, 1);
        cycle(0, 1, 1, 1);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 1);
        check("dis_no_pulse", int'(up), 0);
        repeat (6) cycle(1, 1, 1, 1);
        check("dis_acc7", int'(up), 0);
        cycle(1, 1, 1, 1);
        check("dis_up8", int'(up), 1);

        // Asynchronous reset mid-run
        repeat (3) cycle(1, 1, 1, 1);
        async_reset();

        // Random stimulus with a drifting early/late bias
        p_early = 50;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) == 0) p_early = $urandom_range(0, 100);
            if (i == 1500) async_reset();
            cycle($urandom_range(0, 99) != 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < p_early);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
